// File: rtl/rst_pkg.sv
// Shared FSM state and reset-cause encodings for reset_request_gen and its debouncer.
package rst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_BTN  = 2'b01,
        CAUSE_SW   = 2'b10,
        CAUSE_WDOG = 2'b11
    } cause_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One spare bit over the terminal count so the counter can never wrap.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/reset_request_gen_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer followed by a stability counter that
// qualifies a new level after DEBOUNCE_CYCLES identical samples and flags its rising edge.
module btn_debounce
    import rst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // NOTE: all state here is sequential, so every assignment is non-blocking to
    // avoid read-after-write ordering races between the synchronizer stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta <= btn_in;
            sync <= meta;
            rise <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync;
                rise  <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_request_gen.sv
// Raw reset-request generator: button, software and (with RST_WDOG_EN) watchdog sources
// produce one fixed-width rst_out pulse each, followed by a holdoff window.
module reset_request_gen
    import rst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 16,
    parameter int HOLDOFF_CYCLES  = 1024,
    parameter int WDOG_CYCLES     = 2**24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       sw_req,
`ifdef RST_WDOG_EN
    input  logic       wdog_kick,
`endif
    output logic       rst_out,
    output logic       busy,
    output logic [1:0] rst_cause
);

    localparam int CW = cnt_width(max2(PULSE_CYCLES, HOLDOFF_CYCLES));

    state_t        state;
    cause_t        cause;
    logic [CW-1:0] cnt;
    logic          btn_level;
    logic          btn_rise;
    logic          wdog_req;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .reset (reset),
        .btn_in(btn_in),
        .level (btn_level),
        .rise  (btn_rise)
    );

`ifdef RST_WDOG_EN
    localparam int WW = cnt_width(WDOG_CYCLES);

    logic [WW-1:0] wdog_cnt;

    // Saturates at the terminal count so a late request stays pending until IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= '0;
        end else if (wdog_kick || state == ASSERT) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WW'(WDOG_CYCLES - 1)) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_req = (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
    assign wdog_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ASSERT;
            cnt     <= '0;
            rst_out <= 1'b1;
            busy    <= 1'b1;
            cause   <= CAUSE_POR;
        end else begin
            case (state)
                IDLE: begin
                    if (wdog_req || btn_rise || sw_req) begin
                        state   <= ASSERT;
                        cnt     <= '0;
                        rst_out <= 1'b1;
                        busy    <= 1'b1;
                        if (wdog_req)      cause <= CAUSE_WDOG;
                        else if (btn_rise) cause <= CAUSE_BTN;
                        else               cause <= CAUSE_SW;
                    end
                end
                ASSERT: begin
                    if (cnt == CW'(PULSE_CYCLES - 1)) begin
                        state   <= HOLDOFF;
                        cnt     <= '0;
                        rst_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLDOFF: begin
                    // Counter parks at its terminal value while a held button blocks exit.
                    if (cnt == CW'(HOLDOFF_CYCLES - 1)) begin
                        if (!btn_level) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rst_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign rst_cause = cause;

endmodule
